// File: rtl/dma_pkg.sv
// Shared definitions for the ADMA acknowledge responder: channel indices,
// handshake mode encoding and the control FSM state set.
package dma_pkg;

  // Event / acknowledge channel indices.
  localparam int EV_DMA_INT  = 0;
  localparam int EV_ADMA_ERR = 1;
  localparam int EV_TC       = 2;
  localparam int EV_SAR      = 3;

  // Handshake modes as presented on the mode input.
  typedef enum logic [1:0] {
    MODE_ALWAYS    = 2'd0,
    MODE_PULSE     = 2'd1,
    MODE_FOURPHASE = 2'd2,
    MODE_PULSE_ALT = 2'd3
  } mode_e;

  // Control FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ARB   = 3'd2,
    ST_DELAY = 3'd3,
    ST_ACK   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Fold the raw mode field into the behaviour actually used; the spare
  // encoding behaves exactly like PULSE, so it is never stored.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd0:    return MODE_ALWAYS;
      2'd2:    return MODE_FOURPHASE;
      default: return MODE_PULSE;
    endcase
  endfunction

  // Width of a channel index; never zero so single-channel builds still work.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_ack_responder_if.sv
// Bundle of the run-control, event and acknowledge signals between the ADMA
// engine / host model (master) and the acknowledge responder (slave).
interface dma_ack_responder_if #(
  parameter int ADDR_W = 64,
  parameter int NUM_EV = 4,
  parameter int LAT_W  = 4
);

  logic              start;
  logic [1:0]        mode;
  logic [LAT_W-1:0]  ack_latency;
  logic [NUM_EV-1:0] req;
  logic [NUM_EV-1:0] ack;
  logic [ADDR_W-1:0] Initial_ADMA_System_Address;
  logic              addr_valid;
  logic              busy;
  logic              done;
  logic [NUM_EV-1:0] pend;

  // Responder side.
  modport slave (
    input  start, mode, ack_latency, req,
    output ack, Initial_ADMA_System_Address, addr_valid, busy, done, pend
  );

  // Engine / host side.
  modport master (
    output start, mode, ack_latency, req,
    input  ack, Initial_ADMA_System_Address, addr_valid, busy, done, pend
  );

endinterface

// File: rtl/dma_ack_prio_arb.sv
// Fixed-priority picker: returns the lowest set index of req_vec.
module dma_ack_prio_arb #(
  parameter int NUM_EV = 4,
  parameter int IDX_W  = dma_pkg::idx_width(NUM_EV)
) (
  input  logic [NUM_EV-1:0] req_vec,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int i = NUM_EV - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        gnt_idx   = IDX_W'(i);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_ack_responder.sv
// Host-side responder for the ADMA engine: presents the per-run system
// address and answers event requests with programmable-latency acknowledges
// in ALWAYS, PULSE or FOURPHASE handshake mode.
module dma_ack_responder
  import dma_pkg::*;
#(
  parameter int                ADDR_W     = 64,
  parameter int                NUM_EV     = 4,
  parameter int                TC_IDX     = EV_TC,
  parameter int                LAT_W      = 4,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(1),
  parameter logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'('h200)
) (
  input logic          clk,
  input logic          reset_n,
  dma_ack_responder_if.slave bus
);

  localparam int               IDX_W  = idx_width(NUM_EV);
  localparam logic [IDX_W-1:0] TC_SEL = IDX_W'(TC_IDX);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic [NUM_EV-1:0] pend_q, pend_d;
  logic [NUM_EV-1:0] req_prev_q, req_prev_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [NUM_EV-1:0] req_rise;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;
  logic              ack_exit;

  // Rising edges of the level requests, relative to the previous cycle.
  assign req_rise = bus.req & ~req_prev_q;

  // An acknowledge ends after one cycle, except in FOURPHASE where it is held
  // until the granted request has been withdrawn.
  assign ack_exit = (mode_q != MODE_FOURPHASE) || !bus.req[gnt_q];

  // Lowest-index pending request wins arbitration.
  dma_ack_prio_arb #(
    .NUM_EV (NUM_EV),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req_vec   (pend_q),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  // State and datapath registers; everything returns to its run-free value on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_ALWAYS;
      cnt_q      <= '0;
      gnt_q      <= '0;
      pend_q     <= '0;
      req_prev_q <= '0;
      addr_q     <= START_ADDR;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      pend_q     <= pend_d;
      req_prev_q <= req_prev_d;
      addr_q     <= addr_d;
    end
  end

  // Next-state logic: run sequencing, grant selection and latency countdown.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mode_d  = decode_mode(bus.mode);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_ARB;
      end
      ST_ARB: begin
        if (mode_q == MODE_ALWAYS) begin
          // Everything is already acknowledged; only transfer-complete matters.
          if (req_rise[TC_IDX] || pend_q[TC_IDX]) begin
            state_d = ST_DONE;
          end
        end else if (arb_valid) begin
          gnt_d = arb_idx;
          cnt_d = bus.ack_latency;
          // Zero latency acknowledges on the cycle right after the grant.
          state_d = (bus.ack_latency == '0) ? ST_ACK : ST_DELAY;
        end
      end
      ST_DELAY: begin
        // The counter reaches zero on the cycle the acknowledge appears.
        cnt_d = cnt_q - LAT_W'(1);
        if (cnt_q == LAT_W'(1)) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (ack_exit) begin
          state_d = (gnt_q == TC_SEL) ? ST_DONE : ST_ARB;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pending capture, request history and per-run address advance.
  always_comb begin
    pend_d     = pend_q;
    addr_d     = addr_q;
    req_prev_d = bus.req;
    if (state_q != ST_IDLE) begin
      if (state_q == ST_LOAD) begin
        pend_d = '0;
      end
      if (state_q == ST_ACK && ack_exit) begin
        pend_d[gnt_q] = 1'b0;
      end
      // A new edge wins over the clear, so an edge arriving during its own
      // acknowledge is serviced again later.
      pend_d = pend_d | req_rise;
    end
    if (state_q == ST_DONE) begin
      addr_d = addr_q + ADDR_STEP;
    end
  end

  // Outputs decoded from the current state only.
  always_comb begin
    bus.ack        = '0;
    bus.addr_valid = 1'b0;
    bus.busy       = (state_q != ST_IDLE);
    bus.done       = 1'b0;
    case (state_q)
      ST_LOAD: begin
        bus.addr_valid = 1'b1;
      end
      ST_ARB: begin
        bus.addr_valid = 1'b1;
        if (mode_q == MODE_ALWAYS) begin
          bus.ack = '1;
        end
      end
      ST_DELAY: begin
        bus.addr_valid = 1'b1;
      end
      ST_ACK: begin
        bus.addr_valid = 1'b1;
        bus.ack[gnt_q] = 1'b1;
      end
      ST_DONE: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.busy = (state_q != ST_IDLE);
      end
    endcase
  end

  assign bus.pend                        = pend_q;
  assign bus.Initial_ADMA_System_Address = addr_q;

endmodule

// File: tb/tb_dma_ack_responder.sv
// Self-checking bench for dma_ack_responder: directed handshake scenarios plus
// randomized PULSE runs checked against a transaction-level service model.
module tb_dma_ack_responder;

  localparam int          ADDR_W  = 64;
  localparam int          NUM_EV  = 4;
  localparam int          LAT_W   = 4;
  localparam logic [63:0] START_A = 64'd1;
  localparam logic [63:0] STEP    = 64'h200;
  localparam logic [63:0] START_W = 64'hFFFF_FFFF_FFFF_FF00;
  localparam int          MAXC    = 128;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [63:0] exp_addr;

  // Per-cycle request stimulus and expected acknowledge for randomized runs.
  logic [3:0] rnd_req [MAXC];
  logic [3:0] rnd_ack [MAXC];

  dma_ack_responder_if #(.ADDR_W(ADDR_W), .NUM_EV(NUM_EV), .LAT_W(LAT_W)) bus ();
  dma_ack_responder_if #(.ADDR_W(ADDR_W), .NUM_EV(NUM_EV), .LAT_W(LAT_W)) bus_w ();

  dma_ack_responder #(
    .ADDR_W(ADDR_W), .NUM_EV(NUM_EV), .TC_IDX(2), .LAT_W(LAT_W),
    .START_ADDR(START_A), .ADDR_STEP(STEP)
  ) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  dma_ack_responder #(
    .ADDR_W(ADDR_W), .NUM_EV(NUM_EV), .TC_IDX(2), .LAT_W(LAT_W),
    .START_ADDR(START_W), .ADDR_STEP(STEP)
  ) dut_w (.clk(clk), .reset_n(reset_n), .bus(bus_w));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Pulse start from IDLE (cycle 0); returns positioned in cycle 1 (LOAD).
  task automatic start_run(input logic [1:0] m, input logic [3:0] lat);
    bus.start       = 1'b1;
    bus.mode        = m;
    bus.ack_latency = lat;
    step();
    bus.start = 1'b0;
  endtask

  // True if channel i has a rising edge in any cycle of [lo, hi).
  function automatic bit has_edge(input int i, input int lo, input int hi);
    for (int e = lo; e < hi; e++) begin
      if (e >= 1 && e < MAXC && rnd_req[e][i] && !rnd_req[e-1][i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) step();
    n_tests++; if (bus.ack !== 4'h0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", bus.ack); end
    n_tests++; if (bus.pend !== 4'h0) begin n_fail++; $display("FAIL reset_pend: got %b expected 0000", bus.pend); end
    n_tests++; if (bus.Initial_ADMA_System_Address !== START_A) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", bus.Initial_ADMA_System_Address, START_A); end
    n_tests++; if (bus.addr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_addr_valid: got %b expected 0", bus.addr_valid); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    reset_n = 1'b1;
    exp_addr = START_A;
  endtask

  task automatic test_always();
    start_run(2'd0, 4'd0);
    n_tests++; if (bus.addr_valid !== 1'b1) begin n_fail++; $display("FAIL always_load_valid: got %b expected 1", bus.addr_valid); end
    n_tests++; if (bus.ack !== 4'h0) begin n_fail++; $display("FAIL always_load_ack: got %b expected 0000", bus.ack); end
    for (int c = 2; c <= 3; c++) begin
      step();
      n_tests++; if (bus.ack !== 4'hF) begin n_fail++; $display("FAIL always_ack c%0d: got %b expected 1111", c, bus.ack); end
    end
    bus.req = 4'b0100;
    step();
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL always_done: got %b expected 1", bus.done); end
    n_tests++; if (bus.ack !== 4'h0) begin n_fail++; $display("FAIL always_done_ack: got %b expected 0000", bus.ack); end
    n_tests++; if (bus.addr_valid !== 1'b0) begin n_fail++; $display("FAIL always_done_valid: got %b expected 0", bus.addr_valid); end
    bus.req = 4'b0000;
    step();
    exp_addr += STEP;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL always_idle_busy: got %b expected 0", bus.busy); end
    n_tests++; if (bus.Initial_ADMA_System_Address !== exp_addr) begin n_fail++; $display("FAIL always_addr: got %h expected %h", bus.Initial_ADMA_System_Address, exp_addr); end
  endtask

  task automatic test_pulse_latency();
    bit seen;
    start_run(2'd1, 4'd3);
    step();
    bus.req = 4'b0001;
    step();
    n_tests++; if (bus.pend !== 4'b0001) begin n_fail++; $display("FAIL lat_pend_set: got %b expected 0001", bus.pend); end
    bus.req = 4'b0000;
    for (int c = 4; c <= 6; c++) begin
      step();
      n_tests++; if (bus.ack !== 4'h0) begin n_fail++; $display("FAIL lat_delay_ack c%0d: got %b expected 0000", c, bus.ack); end
    end
    step();
    n_tests++; if (bus.ack !== 4'b0001) begin n_fail++; $display("FAIL lat_ack c7: got %b expected 0001", bus.ack); end
    step();
    n_tests++; if (bus.ack !== 4'h0) begin n_fail++; $display("FAIL lat_ack_width c8: got %b expected 0000", bus.ack); end
    n_tests++; if (bus.pend !== 4'h0) begin n_fail++; $display("FAIL lat_pend_clr: got %b expected 0000", bus.pend); end
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy: got %b expected 1", bus.busy); end
    bus.req = 4'b0100;
    step();
    bus.req = 4'b0000;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      seen = bus.done;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL lat_done_timeout: got no done expected done within 20 cycles"); end
    step();
    exp_addr += STEP;
    n_tests++; if (bus.Initial_ADMA_System_Address !== exp_addr) begin n_fail++; $display("FAIL lat_addr: got %h expected %h", bus.Initial_ADMA_System_Address, exp_addr); end
  endtask

  task automatic test_priority();
    logic [3:0] exp_seq [3:10];
    exp_seq = '{4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
    start_run(2'd1, 4'd0);
    step();
    bus.req = 4'b1010;
    for (int c = 3; c <= 10; c++) begin
      step();
      n_tests++; if (bus.ack !== exp_seq[c]) begin n_fail++; $display("FAIL prio_ack c%0d: got %b expected %b", c, bus.ack, exp_seq[c]); end
      if (c == 3) begin
        n_tests++; if (bus.pend !== 4'b1010) begin n_fail++; $display("FAIL prio_pend c3: got %b expected 1010", bus.pend); end
      end
      if (c == 5) begin
        n_tests++; if (bus.pend !== 4'b1000) begin n_fail++; $display("FAIL prio_pend c5: got %b expected 1000", bus.pend); end
      end
      bus.req = (c == 7) ? 4'b0100 : 4'b0000;
    end
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL prio_done c10: got %b expected 1", bus.done); end
    step();
    exp_addr += STEP;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL prio_busy c11: got %b expected 0", bus.busy); end
    n_tests++; if (bus.Initial_ADMA_System_Address !== exp_addr) begin n_fail++; $display("FAIL prio_addr: got %h expected %h", bus.Initial_ADMA_System_Address, exp_addr); end
  endtask

  task automatic test_fourphase();
    start_run(2'd2, 4'd0);
    step();
    bus.req = 4'b0100;
    step();
    n_tests++; if (bus.ack !== 4'h0) begin n_fail++; $display("FAIL fp_grant_ack c3: got %b expected 0000", bus.ack); end
    for (int c = 4; c <= 8; c++) begin
      step();
      n_tests++; if (bus.ack !== 4'b0100) begin n_fail++; $display("FAIL fp_hold_ack c%0d: got %b expected 0100", c, bus.ack); end
    end
    bus.req = 4'b0000;
    step();
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL fp_done c9: got %b expected 1", bus.done); end
    n_tests++; if (bus.ack !== 4'h0) begin n_fail++; $display("FAIL fp_drop_ack c9: got %b expected 0000", bus.ack); end
    step();
    exp_addr += STEP;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL fp_busy c10: got %b expected 0", bus.busy); end
    n_tests++; if (bus.Initial_ADMA_System_Address !== exp_addr) begin n_fail++; $display("FAIL fp_addr: got %h expected %h", bus.Initial_ADMA_System_Address, exp_addr); end
  endtask

  // Random PULSE runs. The model walks the service sequence: at each
  // arbitration point it picks the lowest channel with an unconsumed edge
  // older than that point; the ack lands lat+1 cycles later and consumes
  // every edge of that channel seen before the ack cycle.
  task automatic test_random_pulse();
    int         thr [4];
    int         t, g, k, done_c, lat;
    logic [1:0] m;
    for (int it = 0; it < 8; it++) begin
      lat = $urandom_range(0, 4);
      m   = ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd1;
      for (int c = 0; c < MAXC; c++) begin
        rnd_req[c] = 4'h0;
        rnd_ack[c] = 4'h0;
      end
      for (int s = 0; s < 7; s++) begin
        for (int i = 0; i < 4; i++) begin
          if (i != 2 && $urandom_range(0, 3) == 0) rnd_req[2 + 3*s][i] = 1'b1;
        end
      end
      rnd_req[2 + 3*$urandom_range(0, 6)][2] = 1'b1;

      for (int i = 0; i < 4; i++) thr[i] = 2;
      t = 2;
      done_c = -1;
      for (int guard = 0; guard < MAXC && done_c < 0; guard++) begin
        g = -1;
        for (int i = 3; i >= 0; i--) begin
          if (has_edge(i, thr[i], t)) g = i;
        end
        if (g < 0) begin
          t++;
        end else begin
          k = t + lat + 1;
          if (k < MAXC) rnd_ack[k] = 4'(1 << g);
          thr[g] = k;
          if (g == 2) done_c = k + 1;
          else        t = k + 1;
        end
      end
      if (done_c < 0 || done_c > MAXC - 2) continue;

      bus.start       = 1'b1;
      bus.mode        = m;
      bus.ack_latency = LAT_W'(lat);
      bus.req         = 4'h0;
      for (int c = 1; c <= done_c + 1; c++) begin
        step();
        n_tests++; if (bus.ack !== rnd_ack[c]) begin n_fail++; $display("FAIL rnd%0d_ack c%0d lat%0d: got %b expected %b", it, c, lat, bus.ack, rnd_ack[c]); end
        n_tests++; if (bus.done !== (c == done_c)) begin n_fail++; $display("FAIL rnd%0d_done c%0d: got %b expected %b", it, c, bus.done, (c == done_c)); end
        if (c == done_c + 1) begin
          exp_addr += STEP;
          n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_busy: got %b expected 0", it, bus.busy); end
          n_tests++; if (bus.Initial_ADMA_System_Address !== exp_addr) begin n_fail++; $display("FAIL rnd%0d_addr: got %h expected %h", it, bus.Initial_ADMA_System_Address, exp_addr); end
        end
        // A start (and a different mode) mid-run must be ignored.
        bus.start = (c == 3);
        bus.mode  = (c == 3) ? 2'd0 : m;
        bus.req   = (c < done_c) ? rnd_req[c] : 4'h0;
      end
      bus.start = 1'b0;
      bus.req   = 4'h0;
    end
  endtask

  task automatic test_addr_wrap();
    bus_w.start = 1'b1;
    bus_w.mode  = 2'd0;
    step();
    bus_w.start = 1'b0;
    step();
    n_tests++; if (bus_w.ack !== 4'hF) begin n_fail++; $display("FAIL wrap_ack: got %b expected 1111", bus_w.ack); end
    bus_w.req = 4'b0100;
    step();
    n_tests++; if (bus_w.done !== 1'b1) begin n_fail++; $display("FAIL wrap_done: got %b expected 1", bus_w.done); end
    n_tests++; if (bus_w.Initial_ADMA_System_Address !== START_W) begin n_fail++; $display("FAIL wrap_addr_pre: got %h expected %h", bus_w.Initial_ADMA_System_Address, START_W); end
    bus_w.req = 4'b0000;
    step();
    n_tests++; if (bus_w.Initial_ADMA_System_Address !== 64'h100) begin n_fail++; $display("FAIL wrap_addr: got %h expected %h", bus_w.Initial_ADMA_System_Address, 64'h100); end
  endtask

  task automatic test_reset_mid();
    start_run(2'd1, 4'd7);
    step();
    bus.req = 4'b0001;
    step();
    bus.req = 4'b0000;
    repeat (3) step();
    n_tests++; if (bus.pend !== 4'b0001) begin n_fail++; $display("FAIL rstmid_pend_pre: got %b expected 0001", bus.pend); end
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_pre: got %b expected 1", bus.busy); end
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if (bus.ack !== 4'h0) begin n_fail++; $display("FAIL rstmid_ack: got %b expected 0000", bus.ack); end
    n_tests++; if (bus.pend !== 4'h0) begin n_fail++; $display("FAIL rstmid_pend: got %b expected 0000", bus.pend); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    n_tests++; if (bus.Initial_ADMA_System_Address !== START_A) begin n_fail++; $display("FAIL rstmid_addr: got %h expected %h", bus.Initial_ADMA_System_Address, START_A); end
    step();
    reset_n  = 1'b1;
    exp_addr = START_A;
    start_run(2'd1, 4'd0);
    step();
    bus.req = 4'b0100;
    step();
    bus.req = 4'b0000;
    step();
    n_tests++; if (bus.ack !== 4'b0100) begin n_fail++; $display("FAIL rstmid_run_ack: got %b expected 0100", bus.ack); end
    step();
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL rstmid_run_done: got %b expected 1", bus.done); end
    step();
    exp_addr += STEP;
    n_tests++; if (bus.Initial_ADMA_System_Address !== exp_addr) begin n_fail++; $display("FAIL rstmid_run_addr: got %h expected %h", bus.Initial_ADMA_System_Address, exp_addr); end
  endtask

  initial begin
    bus.start         = 1'b0;
    bus.mode          = 2'd0;
    bus.ack_latency   = '0;
    bus.req           = '0;
    bus_w.start       = 1'b0;
    bus_w.mode        = 2'd0;
    bus_w.ack_latency = '0;
    bus_w.req         = '0;
    exp_addr          = START_A;
    test_reset();
    test_always();
    test_pulse_latency();
    test_priority();
    test_fourphase();
    test_random_pulse();
    test_addr_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_ack_responder.md
Name: dma_ack_responder

Overview:
- Synthesizable, parametrised successor to the fixed-value DMA bench driver; acts as the host-side responder for the ADMA engine's event outputs.
- Drives the initial ADMA system address per run and answers the N event request lines (DMA interrupt, ADMA error, transfer complete, system-address-register update) with programmable-latency acknowledges.
- Sits between the ADMA engine and the bench or host register model.
- Supports the legacy always-acknowledge mode plus pulse and four-phase handshakes.

Parameters:
- ADDR_W, 64, width of the ADMA system address.
- NUM_EV, 4, number of event/ack channels; index 0 = DMA_Interrupt, 1 = ADMA_Error, 2 = Transfer_complete, 3 = ADMA_System_Address_Register.
- TC_IDX, 2, channel index whose acknowledge ends a run.
- LAT_W, 4, width of the acknowledge-latency field.
- START_ADDR, 1, address loaded at reset.
- ADDR_STEP, 'h200, address increment applied after each completed run.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a run; ignored unless in IDLE.
- mode  in  2  0 = ALWAYS, 1 = PULSE, 2 = FOURPHASE, 3 = treated as PULSE.
- ack_latency  in  LAT_W  cycles from grant to ack assertion.
- req  in  NUM_EV  event requests from the ADMA engine, level.
- ack  out  NUM_EV  acknowledges.
- Initial_ADMA_System_Address  out  ADDR_W  address presented to the engine.
- addr_valid  out  1  high while a run is active.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a run completes.
- pend  out  NUM_EV  sticky pending-request vector.

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE, ack = 0, pend = 0, Initial_ADMA_System_Address = START_ADDR.
  - addr_valid = 0, busy = 0, done = 0, latency counter = 0.
- States: IDLE, LOAD, ARB, DELAY, ACK, DONE.
- IDLE:
  - On start: go to LOAD.
  - mode is sampled at start and held for the whole run.
- LOAD (1 cycle):
  - Assert addr_valid.
  - Clear pend.
  - Go to ARB.
- Pending capture, every cycle outside IDLE: a rising edge of req[i] sets pend[i].
- ARB:
  - If mode = ALWAYS: drive ack = all ones while the run is active. Transfer-complete detection is the rising edge of req[TC_IDX]; go to DONE on it.
  - Otherwise, if pend != 0: grant the lowest set index g, load the counter with ack_latency, go to DELAY.
- DELAY:
  - Decrement the counter.
  - When the counter = 0, go to ACK.
  - ack_latency = 0 gives ack on the cycle after grant.
- ACK, PULSE mode:
  - ack[g] = 1 for exactly 1 cycle.
  - Clear pend[g].
- ACK, FOURPHASE mode:
  - Hold ack[g] = 1 until req[g] is sampled low.
  - Drop ack[g], then clear pend[g].
- After ACK: if g = TC_IDX go to DONE, else return to ARB.
- Edge arriving during its own ack: a new req[g] rising edge that arrives while ack[g] is high is captured and serviced again later.
- DONE (1 cycle):
  - done = 1, ack = 0, addr_valid = 0.
  - Address += ADDR_STEP, wrapping modulo 2^ADDR_W.
  - Go to IDLE.
- Simultaneous events:
  - Multiple pend bits are serviced strictly by lowest index, one at a time.
  - A pend bit set during DELAY for a lower index does not pre-empt the current grant.
- At most one ack bit is high at a time, except in ALWAYS mode.
- Pending requests not yet serviced when TC completes are discarded at the next LOAD.
- start while busy is ignored.
- reset_n low mid-run returns all state to reset values immediately; the address returns to START_ADDR.

Decomposition:
- Shared package dma_pkg:
  - Channel index constants EV_DMA_INT = 0, EV_ADMA_ERR = 1, EV_TC = 2, EV_SAR = 3.
  - mode encoding constants.
  - FSM state enum.
- One natural sub-module: dma_ack_prio_arb, a NUM_EV-wide lowest-index-first fixed-priority picker returning a grant index and valid.

Test Plan:
- Legacy ALWAYS: reset, start with mode = 0, pulse req[2] → ack = 4'b1111 from the cycle after LOAD; done pulses; address changes 1 → 'h201.
- PULSE with latency 3: mode = 1, ack_latency = 3, req[0] rises → ack[0] high for exactly 1 cycle, 4 cycles after the grant cycle; pend[0] clears.
- Priority: req[3] and req[1] rise in the same cycle, PULSE, latency 0 → ack[1] is acked first, then ack[3]; never both high.
- FOURPHASE: mode = 2, req[2] rises and is held 6 cycles → ack[2] stays high until req[2] is low; then done = 1; then busy = 0 the following cycle.
- Address wrap: override START_ADDR = 2^64 - 'h100 and run once → Initial_ADMA_System_Address = 'h100.
- Reset mid-run: assert reset_n = 0 during DELAY → ack = 0, pend = 0, busy = 0, address = START_ADDR asynchronously; start after release works normally.
